// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// default operand/result sizes and the FSM state encodings.
package bin_to_bcd_seq_pkg;

  localparam int unsigned DEF_WIDTH  = 17;
  localparam int unsigned DEF_DIGITS = 6;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Add-3 correction ahead of the shift
  always_comb begin
    digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter. One operand bit is
// shifted into the BCD scratch register per clock; the result and its count
// of significant digits are registered on the final shift and held until the
// next conversion completes.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic [2:0]            ndigits
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SW    = DIGITS * 4;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SW-1:0]      scratch;
  logic [SW-1:0]      scratch_adj;
  logic [SW-1:0]      scratch_nxt;
  logic [WIDTH-1:0]   operand;
  logic [2:0]         nd_nxt;
  logic               last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[g*4 +: 4]),
      .digit_out (scratch_adj[g*4 +: 4])
    );
  end

  // Next scratch value and end-of-conversion detection
  always_comb begin
    scratch_nxt = {scratch_adj[SW-2:0], operand[WIDTH-1]};
    last_shift  = (cnt == CNT_W'(WIDTH - 1));
  end

  // Significant-digit count of the value about to be loaded (zero reports 1)
  always_comb begin
    nd_nxt = 3'd1;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (scratch_nxt[i*4 +: 4] != 4'd0) nd_nxt = 3'(i + 1);
    end
  end

  // Status outputs decoded from state only, so start never reaches them combinationally
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Conversion FSM, datapath and result registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      scratch <= '0;
      operand <= '0;
      bcd_out <= '0;
      ndigits <= 3'd1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            operand <= bin_in;
            scratch <= '0;
            cnt     <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_nxt;
          operand <= {operand[WIDTH-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          if (last_shift) begin
            bcd_out <= scratch_nxt;
            ndigits <= nd_nxt;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq at default parameters.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [16:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic [2:0]  ndigits;

  int n_checks = 0;
  int n_pass   = 0;

  bin_to_bcd_seq #(.WIDTH(17), .DIGITS(6)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .ndigits  (ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int ref_nd(input int unsigned v);
    int n;
    int unsigned t;
    n = 1;
    t = v;
    for (int i = 1; i < 6; i++) begin
      t = t / 10;
      if (t != 0) n = i + 1;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start with an operand and step past the accepting edge
  task automatic launch(input logic [16:0] v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    tick();
  endtask

  // Called just after the accepting edge: wait for done and check the result
  task automatic finish_conv(input string tag, input int unsigned v);
    int lat;
    int bad;
    logic [23:0] exp;
    exp = ref_bcd(v);
    check_eq({tag, "_busy_accept"}, 32'(busy), 32'd1);
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~bin_in;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd17);
    check_eq({tag, "_bcd"}, 32'(bcd_out), 32'(exp));
    check_eq({tag, "_ndigits"}, 32'(ndigits), 32'(ref_nd(v)));
    bad = 0;
    for (int i = 0; i < 6; i++) if (bcd_out[i*4 +: 4] > 4'd9) bad++;
    check_eq({tag, "_digit_range"}, 32'(bad), 32'd0);
    tick();
    check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    tick();
    tick();
    check_eq({tag, "_hold"}, 32'(bcd_out), 32'(exp));
  endtask

  task automatic convert(input string tag, input int unsigned v);
    launch(17'(v));
    finish_conv(tag, v);
  endtask

  int unsigned vecs [] = '{0, 1, 9, 10, 99, 100, 999, 1000, 4999, 5000, 9999, 10000,
                           12345, 54321, 65535, 65536, 77777, 80808, 99999, 100000,
                           131070, 131071};

  initial begin
    int ndone;
    int busy_drop;
    int first_e;
    int second_e;
    logic [23:0] cap;
    logic [23:0] first_bcd;
    logic [23:0] second_bcd;

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    #2;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_bcd", 32'(bcd_out), 32'd0);
    check_eq("rst_ndigits", 32'(ndigits), 32'd1);

    // Release reset with start already high: the first edge must accept
    @(negedge clk);
    reset  = 1'b0;
    start  = 1'b1;
    bin_in = 17'd0;
    tick();
    finish_conv("zero", 0);

    convert("max", 131071);
    convert("n999", 999);

    // Restart attempt with a new operand mid-conversion is ignored
    launch(17'd255);
    ndone = 0;
    busy_drop = 0;
    cap = '0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      if (e == 1) start = 1'b0;
      if (e == 5) begin
        start  = 1'b1;
        bin_in = 17'd7;
      end
      if (e == 7) start = 1'b0;
      tick();
      if (done) begin
        ndone++;
        cap = bcd_out;
      end
      if (e <= 17 && !busy) busy_drop++;
    end
    check_eq("restart_done_count", 32'(ndone), 32'd1);
    check_eq("restart_busy_drop", 32'(busy_drop), 32'd0);
    check_eq("restart_bcd", 32'(cap), 32'h000255);

    // Abort with reset on cycle 9, then restart on the first edge after release
    launch(17'd4321);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e < 9; e++) tick();
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_bcd", 32'(bcd_out), 32'd0);
    check_eq("abort_ndigits", 32'(ndigits), 32'd1);
    ndone = 0;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (done) ndone++;
    end
    check_eq("abort_no_done", 32'(ndone), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    start  = 1'b1;
    bin_in = 17'd4321;
    tick();
    finish_conv("after_abort", 4321);

    // start held high: accepts 19 edges apart (one IDLE cycle between runs)
    launch(17'd10);
    @(negedge clk);
    bin_in = 17'd20;
    first_e = -1;
    second_e = -1;
    first_bcd = '0;
    second_bcd = '0;
    for (int e = 1; e <= 60 && second_e < 0; e++) begin
      tick();
      if (done) begin
        if (first_e < 0) begin
          first_e = e;
          first_bcd = bcd_out;
        end else begin
          second_e = e;
          second_bcd = bcd_out;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_first_edge", 32'(first_e), 32'd17);
    check_eq("b2b_spacing", 32'(second_e - first_e), 32'd19);
    check_eq("b2b_first_bcd", 32'(first_bcd), 32'h000010);
    check_eq("b2b_second_bcd", 32'(second_bcd), 32'h000020);
    for (int e = 0; e < 25; e++) tick();
    check_eq("b2b_idle", 32'(busy), 32'd0);

    foreach (vecs[i]) convert($sformatf("vec%0d", vecs[i]), vecs[i]);
    for (int i = 0; i < 12; i++) begin
      int unsigned r;
      r = $urandom_range(131071, 0);
      convert($sformatf("rnd%0d", r), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
